// File: rtl/decode.sv
// LC3 decode stage: waits out the instruction memory latency, captures the word,
// splits it into fields, reads the register file and hands the result back to fetch.
module decode #(
  parameter int MEM_LAT = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        decode_start,
  input  logic [15:0] instr_in,
  input  logic        wb_en,
  input  logic [2:0]  wb_dr,
  input  logic [15:0] wb_data,
  output logic        busy,
  output logic        decode_valid,
  output logic        fetch_start,
  output logic [3:0]  opCode_out,
  output logic [8:0]  offset_out,
  output logic [2:0]  br_nzp,
  output logic [2:0]  result_nzp,
  output logic [2:0]  dr_out,
  output logic        imm_flag,
  output logic [15:0] imm_out,
  output logic [15:0] reg_out,
  output logic [15:0] sr2_data
);

  typedef enum logic [1:0] {IDLE, WAIT, ISSUE} state_t;

  localparam logic [1:0] CNT_INIT = 2'(MEM_LAT - 1);

  state_t      state_reg, state_next;
  logic [1:0]  cnt_reg, cnt_next;
  logic [15:0] rf [8];
  logic [7:0]  wr_sel;
  logic [2:0]  cc_next;
  logic        capture;
  logic [2:0]  src1, src2;
  logic [15:0] rd1, rd2;

  assign capture = (state_reg == WAIT) && (cnt_reg == 2'd0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    case (state_reg)
      IDLE: begin
        if (decode_start) begin
          state_next = WAIT;
          cnt_next   = CNT_INIT;
        end
      end
      WAIT: begin
        if (cnt_reg == 2'd0) state_next = ISSUE;
        else                 cnt_next   = cnt_reg - 2'd1;
      end
      ISSUE:   state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign busy         = (state_reg != IDLE);
  assign decode_valid = (state_reg == ISSUE);
  assign fetch_start  = (state_reg == ISSUE);

  for (genvar gi = 0; gi < 8; gi++) begin : g_wr_sel
    assign wr_sel[gi] = wb_en && (wb_dr == 3'(gi));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 8; i++) rf[i] <= '0;
    end else begin
      for (int i = 0; i < 8; i++) begin
        if (wr_sel[i]) rf[i] <= wb_data;
      end
    end
  end

  always_comb begin
    cc_next = 3'b001;
    if (wb_data[15])           cc_next = 3'b100;
    else if (wb_data == 16'h0) cc_next = 3'b010;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     result_nzp <= 3'b010;
    else if (wb_en) result_nzp <= cc_next;
  end

  // Forward a same-edge writeback so the decoded operand is never stale.
  assign src1 = instr_in[8:6];
  assign src2 = instr_in[2:0];
  assign rd1  = (wb_en && wb_dr == src1) ? wb_data : rf[src1];
  assign rd2  = (wb_en && wb_dr == src2) ? wb_data : rf[src2];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      opCode_out <= '0;
      offset_out <= '0;
      br_nzp     <= '0;
      dr_out     <= '0;
      imm_flag   <= 1'b0;
      imm_out    <= '0;
      reg_out    <= '0;
      sr2_data   <= '0;
    end else if (capture) begin
      opCode_out <= instr_in[15:12];
      offset_out <= instr_in[8:0];
      br_nzp     <= (instr_in[15:12] == 4'b0000) ? instr_in[11:9] : 3'b000;
      dr_out     <= instr_in[11:9];
      imm_flag   <= instr_in[5];
      imm_out    <= {{11{instr_in[4]}}, instr_in[4:0]};
      reg_out    <= rd1;
      sr2_data   <= rd2;
    end
  end

endmodule

// File: tb/tb_decode.sv
// Directed bench for decode: one MEM_LAT=1 and one MEM_LAT=3 instance, expected
// decode results queued at stimulus time and checked when decode_valid pulses.
module tb_decode;

  typedef struct {
    logic [3:0]  op;
    logic [8:0]  off;
    logic [2:0]  nzp;
    logic [2:0]  dr;
    logic        immf;
    logic [15:0] imm;
    logic [15:0] rv;
    logic [15:0] sr2;
    int          cyc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start1 = 1'b0, start3 = 1'b0;
  logic [15:0] instr = '0;
  logic        wb_en = 1'b0;
  logic [2:0]  wb_dr = '0;
  logic [15:0] wb_data = '0;

  logic        busy1, dv1, fs1, immf1;
  logic [3:0]  op1;
  logic [8:0]  off1;
  logic [2:0]  nzp1, cc1, dr1;
  logic [15:0] imm1, rv1, sr21;
  logic        busy3, dv3, fs3, immf3;
  logic [3:0]  op3;
  logic [8:0]  off3;
  logic [2:0]  nzp3, cc3, dr3;
  logic [15:0] imm3, rv3, sr23;

  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  exp_t q1[$];
  exp_t q3[$];
  logic [15:0] mreg [8];
  logic [2:0]  mcc;

  decode #(.MEM_LAT(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .decode_start(start1), .instr_in(instr),
    .wb_en(wb_en), .wb_dr(wb_dr), .wb_data(wb_data),
    .busy(busy1), .decode_valid(dv1), .fetch_start(fs1), .opCode_out(op1),
    .offset_out(off1), .br_nzp(nzp1), .result_nzp(cc1), .dr_out(dr1),
    .imm_flag(immf1), .imm_out(imm1), .reg_out(rv1), .sr2_data(sr21)
  );

  decode #(.MEM_LAT(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .decode_start(start3), .instr_in(instr),
    .wb_en(wb_en), .wb_dr(wb_dr), .wb_data(wb_data),
    .busy(busy3), .decode_valid(dv3), .fetch_start(fs3), .opCode_out(op3),
    .offset_out(off3), .br_nzp(nzp3), .result_nzp(cc3), .dr_out(dr3),
    .imm_flag(immf3), .imm_out(imm3), .reg_out(rv3), .sr2_data(sr23)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [15:0] obs, input logic [15:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", name, obs, expv);
    end
  endtask

  function automatic exp_t model(input logic [15:0] i, input logic byp,
                                 input logic [2:0] bdr, input logic [15:0] bdata, input int c);
    exp_t e;
    e.op   = i[15:12];
    e.off  = i[8:0];
    e.nzp  = (i[15:12] == 4'h0) ? i[11:9] : 3'b000;
    e.dr   = i[11:9];
    e.immf = i[5];
    e.imm  = {{11{i[4]}}, i[4:0]};
    e.rv   = (byp && bdr == i[8:6]) ? bdata : mreg[i[8:6]];
    e.sr2  = (byp && bdr == i[2:0]) ? bdata : mreg[i[2:0]];
    e.cyc  = c;
    return e;
  endfunction

  function automatic logic [2:0] cc_of(input logic [15:0] d);
    if (d[15]) return 3'b100;
    if (d == 16'h0) return 3'b010;
    return 3'b001;
  endfunction

  task automatic check_pulse(input string who, input exp_t e, input logic fs, input logic [3:0] op,
                             input logic [8:0] off, input logic [2:0] nzp, input logic [2:0] dr,
                             input logic immf, input logic [15:0] imm, input logic [15:0] rv,
                             input logic [15:0] sr2);
    chk({who, "_latency"}, 16'(cyc), 16'(e.cyc));
    chk({who, "_fetch_start"}, 16'(fs), 16'h1);
    chk({who, "_opcode"}, 16'(op), 16'(e.op));
    chk({who, "_offset"}, 16'(off), 16'(e.off));
    chk({who, "_br_nzp"}, 16'(nzp), 16'(e.nzp));
    chk({who, "_dr"}, 16'(dr), 16'(e.dr));
    chk({who, "_imm_flag"}, 16'(immf), 16'(e.immf));
    chk({who, "_imm"}, imm, e.imm);
    chk({who, "_reg_out"}, rv, e.rv);
    chk({who, "_sr2"}, sr2, e.sr2);
    $display("decode %s op=%h off=%h nzp=%b reg=%h sr2=%h at cycle %0d", who, op, off, nzp, rv, sr2, cyc);
  endtask

  always @(negedge clk) begin
    if (dv1) begin
      if (q1.size() == 0) chk("dut1_unexpected_pulse", 16'(dv1), 16'h0);
      else check_pulse("dut1", q1.pop_front(), fs1, op1, off1, nzp1, dr1, immf1, imm1, rv1, sr21);
    end
    if (dv3) begin
      if (q3.size() == 0) chk("dut3_unexpected_pulse", 16'(dv3), 16'h0);
      else check_pulse("dut3", q3.pop_front(), fs3, op3, off3, nzp3, dr3, immf3, imm3, rv3, sr23);
    end
  end

  task automatic wb(input logic [2:0] d, input logic [15:0] v);
    @(negedge clk);
    wb_en = 1'b1; wb_dr = d; wb_data = v;
    @(negedge clk);
    wb_en = 1'b0;
    mreg[d] = v;
    mcc = cc_of(v);
    chk("result_nzp", 16'(cc1), 16'(mcc));
    $display("writeback R%0d=%h result_nzp=%b", d, v, cc1);
  endtask

  // MEM_LAT=1 decode; optional writeback driven on the capture edge.
  task automatic decode1(input logic [15:0] i, input logic byp,
                         input logic [2:0] bdr, input logic [15:0] bdata);
    @(negedge clk);
    instr = i; start1 = 1'b1;
    q1.push_back(model(i, byp, bdr, bdata, cyc + 2));
    @(negedge clk);
    start1 = 1'b0;
    if (byp) begin wb_en = 1'b1; wb_dr = bdr; wb_data = bdata; end
    @(negedge clk);
    if (byp) begin
      wb_en = 1'b0;
      mreg[bdr] = bdata;
      mcc = cc_of(bdata);
    end
    repeat (3) @(negedge clk);
  endtask

  initial begin
    for (int i = 0; i < 8; i++) mreg[i] = '0;
    mcc = 3'b010;
    repeat (5) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_busy", 16'(busy1), 16'h0);
    chk("rst_valid", 16'(dv1), 16'h0);
    chk("rst_fetch_start", 16'(fs1), 16'h0);
    chk("rst_opcode", 16'(op1), 16'h0);
    chk("rst_offset", 16'(off1), 16'h0);
    chk("rst_br_nzp", 16'(nzp1), 16'h0);
    chk("rst_result_nzp", 16'(cc1), 16'h2);
    chk("rst_dr", 16'(dr1), 16'h0);
    chk("rst_imm_flag", 16'(immf1), 16'h0);
    chk("rst_imm", imm1, 16'h0);
    chk("rst_reg_out", rv1, 16'h0);
    chk("rst_sr2", sr21, 16'h0);
    chk("rst_busy3", 16'(busy3), 16'h0);

    decode1(16'h07FE, 1'b0, 3'd0, 16'h0);
    wb(3'd3, 16'h3000);
    decode1(16'hC0C0, 1'b0, 3'd0, 16'h0);
    wb(3'd0, 16'h8000);
    wb(3'd0, 16'h0000);
    wb(3'd1, 16'h0005);
    decode1(16'h1261, 1'b1, 3'd1, 16'h0042);
    chk("bypass_cc", 16'(cc1), 16'(mcc));
    decode1(16'h1AF3, 1'b0, 3'd0, 16'h0);

    // MEM_LAT=3 with a second start while busy; only one result expected.
    @(negedge clk);
    instr = 16'h5A3F; start3 = 1'b1;
    q3.push_back(model(16'h5A3F, 1'b0, 3'd0, 16'h0, cyc + 4));
    @(negedge clk);
    start3 = 1'b0;
    chk("busy3_wait", 16'(busy3), 16'h1);
    @(negedge clk);
    start3 = 1'b1;
    @(negedge clk);
    start3 = 1'b0;
    repeat (8) @(negedge clk);
    chk("busy3_idle", 16'(busy3), 16'h0);

    // Reset during WAIT aborts the decode with no pulse.
    @(negedge clk);
    instr = 16'h0E01; start3 = 1'b1;
    @(negedge clk);
    start3 = 1'b0;
    #2 rst_n = 1'b0;
    #1 chk("abort_busy3", 16'(busy3), 16'h0);
    chk("abort_opcode3", 16'(op3), 16'h0);
    chk("abort_reg3", rv3, 16'h0);
    chk("abort_cc3", 16'(cc3), 16'h2);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (6) @(negedge clk);
    chk("abort_valid3", 16'(dv3), 16'h0);
    chk("abort_br_nzp3", 16'(nzp3), 16'h0);
    chk("abort_sr2_3", sr23, 16'h0);

    chk("q1_pending", 16'(q1.size()), 16'h0);
    chk("q3_pending", 16'(q3.size()), 16'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
